el2_dec_trigger_ctl: RTL and testbench

Sequences decode-stage trigger matches into a single registered trigger request for the TLU.
- Inputs are the raw per-trigger PC/opcode match vector, produced by the decode trigger compare logic.
- Applies chain pairing, debug-mode masking and action priority.
- Holds the request until the TLU acknowledges it, then blanks further captures until the pipeline flush.
- Maintains the sticky per-trigger hit bits that are visible through tdata1.

---
 rtl/el2_pkg.sv | 13 +
 rtl/el2_dec_trigger_chain.sv | 26 ++
 rtl/el2_dec_trigger_ctl.sv | 104 ++++++++++
 tb/tb_el2_dec_trigger_ctl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared types and constants for the decode trigger sequencer.
package el2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BLANK = 2'd2
   } el2_trig_state_t;

   localparam logic TRIG_ACT_BRK = 1'b0;
   localparam logic TRIG_ACT_DBG = 1'b1;

endpackage

// File: rtl/el2_dec_trigger_chain.sv
// Per-pair chain qualification of raw decode trigger matches, masked in debug mode.
module el2_dec_trigger_chain #(
   parameter int NUM_TRIG = 4
) (
   input  logic [NUM_TRIG-1:0] raw_match,
   input  logic [NUM_TRIG-1:0] chain,
   input  logic                dbg_mode,
   output logic [NUM_TRIG-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TRIG/2; gi++) begin : g_pair
         logic pair_both;
         logic unused_odd_chain;

         // A chained pair fires only when both halves match, and then reports both.
         assign pair_both        = raw_match[2*gi] & raw_match[2*gi+1];
         assign unused_odd_chain = chain[2*gi+1];

         assign q[2*gi]   = ~dbg_mode & (chain[2*gi] ? pair_both : raw_match[2*gi]);
         assign q[2*gi+1] = ~dbg_mode & (chain[2*gi] ? pair_both : raw_match[2*gi+1]);
      end
   endgenerate

endmodule

// File: rtl/el2_dec_trigger_ctl.sv
// Turns qualified decode trigger matches into one held request to the TLU,
// blanks further captures until flush, and keeps sticky per-trigger hit bits.
module el2_dec_trigger_ctl
   import el2_pkg::*;
#(
   parameter int NUM_TRIG = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_TRIG-1:0] raw_match,
   input  logic                i0_decode_d,
   input  logic                dbg_mode,
   input  logic [NUM_TRIG-1:0] chain,
   input  logic [NUM_TRIG-1:0] action,
   input  logic                flush,
   input  logic                tlu_ack,
   input  logic [NUM_TRIG-1:0] hit_clr,
   output logic                trig_req,
   output logic                trig_action,
   output logic [NUM_TRIG-1:0] trig_match_r,
   output logic [NUM_TRIG-1:0] trig_hit,
   output logic                trig_busy
);

   el2_trig_state_t     state_reg, state_next;
   logic [NUM_TRIG-1:0] match_reg, match_next;
   logic                action_reg, action_next;
   logic [NUM_TRIG-1:0] hit_reg, hit_next;
   logic [NUM_TRIG-1:0] q;
   logic                fire;
   logic                act;

   el2_dec_trigger_chain #(.NUM_TRIG(NUM_TRIG)) u_chain (
      .raw_match (raw_match),
      .chain     (chain),
      .dbg_mode  (dbg_mode),
      .q         (q)
   );

   assign fire = (|q) & i0_decode_d;
   // Any enter-debug trigger in the qualified set overrides breakpoint.
   assign act  = (|(q & action)) ? TRIG_ACT_DBG : TRIG_ACT_BRK;

   always_comb begin
      state_next  = state_reg;
      match_next  = match_reg;
      action_next = action_reg;
      case (state_reg)
         IDLE: begin
            if (fire && !flush) begin
               state_next  = REQ;
               match_next  = q;
               action_next = act;
            end
         end
         REQ: begin
            if (flush) begin
               state_next  = IDLE;
               match_next  = '0;
               action_next = 1'b0;
            end else if (tlu_ack) begin
               state_next = BLANK;
            end
         end
         BLANK: begin
            if (flush) begin
               state_next  = IDLE;
               match_next  = '0;
               action_next = 1'b0;
            end
         end
         default: begin
            state_next  = IDLE;
            match_next  = '0;
            action_next = 1'b0;
         end
      endcase
   end

   // Set is ORed in after the clear so an acknowledged hit survives a same-cycle clear.
   assign hit_next = (hit_reg & ~hit_clr)
                   | ({NUM_TRIG{(state_reg == REQ) && tlu_ack}} & match_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         match_reg  <= '0;
         action_reg <= 1'b0;
         hit_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         match_reg  <= match_next;
         action_reg <= action_next;
         hit_reg    <= hit_next;
      end
   end

   assign trig_req     = (state_reg == REQ);
   assign trig_busy    = (state_reg != IDLE);
   assign trig_action  = action_reg;
   assign trig_match_r = match_reg;
   assign trig_hit     = hit_reg;

endmodule

// File: tb/tb_el2_dec_trigger_ctl.sv
// Directed and randomized check of el2_dec_trigger_ctl against a behavioural model.
module tb_el2_dec_trigger_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] raw_match;
   logic       i0_decode_d;
   logic       dbg_mode;
   logic [3:0] chain;
   logic [3:0] action;
   logic       flush;
   logic       tlu_ack;
   logic [3:0] hit_clr;
   logic       trig_req;
   logic       trig_action;
   logic [3:0] trig_match_r;
   logic [3:0] trig_hit;
   logic       trig_busy;

   int errors = 0;
   int checks = 0;

   // Behavioural model: request outstanding, blanked-until-flush, captured data, sticky hits.
   bit       m_pending;
   bit       m_blanked;
   bit [3:0] m_match;
   bit       m_act;
   bit [3:0] m_hit;

   always #5 clk = ~clk;

   el2_dec_trigger_ctl #(.NUM_TRIG(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .raw_match    (raw_match),
      .i0_decode_d  (i0_decode_d),
      .dbg_mode     (dbg_mode),
      .chain        (chain),
      .action       (action),
      .flush        (flush),
      .tlu_ack      (tlu_ack),
      .hit_clr      (hit_clr),
      .trig_req     (trig_req),
      .trig_action  (trig_action),
      .trig_match_r (trig_match_r),
      .trig_hit     (trig_hit),
      .trig_busy    (trig_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".req"},    32'(trig_req),     32'(m_pending));
      chk({tag, ".busy"},   32'(trig_busy),    32'(m_pending | m_blanked));
      chk({tag, ".match"},  32'(trig_match_r), 32'(m_match));
      chk({tag, ".action"}, 32'(trig_action),  32'(m_act));
      chk({tag, ".hit"},    32'(trig_hit),     32'(m_hit));
   endtask

   function automatic bit [3:0] qualify(input bit [3:0] rm, input bit [3:0] ch, input bit dbg);
      bit [3:0] r;
      r = 4'b0000;
      if (!dbg) begin
         for (int p = 0; p < 2; p++) begin
            if (ch[2*p]) begin
               r[2*p]   = rm[2*p] && rm[2*p+1];
               r[2*p+1] = rm[2*p] && rm[2*p+1];
            end else begin
               r[2*p]   = rm[2*p];
               r[2*p+1] = rm[2*p+1];
            end
         end
      end
      return r;
   endfunction

   // Drive one cycle of inputs, advance the model by one clock, then compare.
   task automatic cycle(input string tag, input bit [3:0] rm, input bit dec, input bit dbg,
                        input bit [3:0] ch, input bit [3:0] act, input bit fl,
                        input bit ack, input bit [3:0] hc);
      bit [3:0] q;
      bit [3:0] n_hit;
      raw_match = rm; i0_decode_d = dec; dbg_mode = dbg; chain = ch;
      action = act; flush = fl; tlu_ack = ack; hit_clr = hc;
      q = qualify(rm, ch, dbg);
      n_hit = (m_hit & ~hc) | ((m_pending && ack) ? m_match : 4'b0000);
      if (m_pending) begin
         if (fl) begin
            m_pending = 0; m_match = 0; m_act = 0;
         end else if (ack) begin
            m_pending = 0; m_blanked = 1;
         end
      end else if (m_blanked) begin
         if (fl) begin
            m_blanked = 0; m_match = 0; m_act = 0;
         end
      end else if (q != 0 && dec && !fl) begin
         m_pending = 1; m_match = q; m_act = (q & act) != 0;
      end
      m_hit = n_hit;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic model_reset();
      m_pending = 0; m_blanked = 0; m_match = 0; m_act = 0; m_hit = 0;
   endtask

   initial begin
      rst = 1'b1;
      raw_match = 0; i0_decode_d = 0; dbg_mode = 0; chain = 0;
      action = 0; flush = 0; tlu_ack = 0; hit_clr = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // Unchained match, then ack into blank, then flush back to idle.
      cycle("unch_fire", 4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      chk("unch_req_const", 32'(trig_req), 32'd1);
      chk("unch_match_const", 32'(trig_match_r), 32'h4);
      cycle("unch_ack", 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 4'b0000);
      chk("unch_hit_const", 32'(trig_hit), 32'h4);
      chk("unch_blank_busy", 32'(trig_busy), 32'd1);
      cycle("blank_ignore", 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      cycle("blank_flush", 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000);
      chk("blank_flush_req", 32'(trig_req), 32'd0);
      cycle("clr_all", 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111);

      // Chained pair (0,1).
      cycle("chain_half", 4'b0001, 1, 0, 4'b0001, 4'b0000, 0, 0, 4'b0000);
      chk("chain_half_req", 32'(trig_req), 32'd0);
      cycle("chain_both", 4'b0011, 1, 0, 4'b0001, 4'b0000, 0, 0, 4'b0000);
      chk("chain_both_match", 32'(trig_match_r), 32'h3);
      // Flush without ack drops the request and leaves hits alone.
      cycle("req_flush", 4'b0000, 0, 0, 4'b0001, 4'b0000, 1, 0, 4'b0000);
      chk("req_flush_hit", 32'(trig_hit), 32'h0);
      chk("req_flush_busy", 32'(trig_busy), 32'd0);

      // Action priority and debug-mode masking.
      cycle("act_fire", 4'b1001, 1, 0, 4'b0000, 4'b1000, 0, 0, 4'b0000);
      chk("act_const", 32'(trig_action), 32'd1);
      cycle("act_flush", 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000);
      chk("act_cleared", 32'(trig_action), 32'd0);
      cycle("dbg_mask", 4'b1001, 1, 1, 4'b0000, 4'b1000, 0, 0, 4'b0000);
      chk("dbg_mask_req", 32'(trig_req), 32'd0);

      // Fire and flush together in idle.
      cycle("fire_flush", 4'b0100, 1, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000);
      chk("fire_flush_req", 32'(trig_req), 32'd0);

      // Ack together with flush returns straight to idle with hit set.
      cycle("af_fire", 4'b0011, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      cycle("af_ackflush", 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 4'b0000);
      chk("af_busy", 32'(trig_busy), 32'd0);
      chk("af_hit", 32'(trig_hit), 32'h3);
      cycle("clr_all2", 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1111);

      // Hit clear, and set winning over a same-cycle clear.
      cycle("hc_fire", 4'b0110, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      cycle("hc_ack", 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 4'b0000);
      chk("hc_hit0110", 32'(trig_hit), 32'h6);
      cycle("hc_clr", 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0010);
      chk("hc_hit0100", 32'(trig_hit), 32'h4);
      cycle("hc_fire2", 4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      cycle("hc_setwins", 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 4'b0100);
      chk("hc_setwins_hit", 32'(trig_hit), 32'h4);
      cycle("hc_flush", 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000);

      // Asynchronous reset in the middle of a request.
      cycle("rst_fire", 4'b1000, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      chk("rst_pre_req", 32'(trig_req), 32'd1);
      raw_match = 0; i0_decode_d = 0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle("rst_refire", 4'b0010, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000);
      chk("rst_refire_req", 32'(trig_req), 32'd1);
      cycle("rst_reflush", 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000);

      // Randomized traffic.
      begin
         bit [3:0] ch_r;
         ch_r = 4'($urandom);
         for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) ch_r = 4'($urandom);
            cycle("rand", 4'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, ch_r,
                  4'($urandom), ($urandom % 5) == 0, ($urandom % 3) == 0,
                  (($urandom % 6) == 0) ? 4'($urandom) : 4'b0000);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
